if_stage: RTL and testbench

Instruction-fetch stage: owns fetch-address sequencing, drives the single-cycle synchronous instruction memory, and presents fetched instructions to the IF/ID pipeline register with the valid / ready_go / allow_in handshake. It keeps at most one outstanding fetch and one skid-buffered instruction, so no response is lost when decode back-pressures. It is redirected by execute on mispredict or jump, and optionally predicts taken for statically predictable control flow.

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage_if.sv | 52 +++++
 rtl/if_stage_static_bp.sv | 37 +++
 rtl/if_stage.sv | 156 +++++++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the bus widths, the RISC-V opcodes the static predictor looks at,
// the fetch FSM state encoding and the default reset PC.
package if_stage_pkg;

   localparam int unsigned BUS_WIDTH  = 32;
   localparam int unsigned DATA_WIDTH = 32;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      IF_BOOT = 2'd0,
      IF_RUN  = 2'd1,
      IF_HOLD = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's bus signals: execute redirect, IF/ID handshake,
// instruction-memory request/response and the presented instruction.
// The master modport is the fetch stage's view; slave is its environment.
interface if_stage_if #(
   parameter int unsigned BUS_WIDTH  = if_stage_pkg::BUS_WIDTH,
   parameter int unsigned DATA_WIDTH = if_stage_pkg::DATA_WIDTH
);

   logic                  redirect_valid;
   logic [BUS_WIDTH-1:0]  redirect_pc;
   logic                  allow_in_id;
   logic                  imem_req;
   logic [BUS_WIDTH-1:0]  imem_addr;
   logic [DATA_WIDTH-1:0] imem_rdata;
   logic                  valid_if;
   logic                  ready_go_if;
   logic [BUS_WIDTH-1:0]  pc_if;
   logic [DATA_WIDTH-1:0] instruction_if;
   logic                  bp_taken_if;
   logic [BUS_WIDTH-1:0]  pre_taken_target_if;

   modport master (
      input  redirect_valid,
      input  redirect_pc,
      input  allow_in_id,
      input  imem_rdata,
      output imem_req,
      output imem_addr,
      output valid_if,
      output ready_go_if,
      output pc_if,
      output instruction_if,
      output bp_taken_if,
      output pre_taken_target_if
   );

   modport slave (
      output redirect_valid,
      output redirect_pc,
      output allow_in_id,
      output imem_rdata,
      input  imem_req,
      input  imem_addr,
      input  valid_if,
      input  ready_go_if,
      input  pc_if,
      input  instruction_if,
      input  bp_taken_if,
      input  pre_taken_target_if
   );

endinterface

// File: rtl/if_stage_static_bp.sv
// static_bp: combinational predecoder used when STATIC_BP_EN is defined.
// JAL is always predicted taken; conditional branches are predicted taken
// only when their offset is negative (backward loops). Everything else
// falls through to pc+4.
module static_bp #(
   parameter int unsigned BUS_WIDTH  = if_stage_pkg::BUS_WIDTH,
   parameter int unsigned DATA_WIDTH = if_stage_pkg::DATA_WIDTH
) (
   input  logic [BUS_WIDTH-1:0]  pc_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   output logic                  taken_o,
   output logic [BUS_WIDTH-1:0]  target_o
);
   import if_stage_pkg::*;

   logic [BUS_WIDTH-1:0] j_imm;
   logic [BUS_WIDTH-1:0] b_imm;

   assign j_imm = {{(BUS_WIDTH-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};
   assign b_imm = {{(BUS_WIDTH-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};

   // Classify the opcode and pick the predicted next PC.
   always_comb begin
      taken_o  = 1'b0;
      target_o = pc_i + BUS_WIDTH'(4);
      if (instr_i[6:0] == OPCODE_JAL) begin
         taken_o  = 1'b1;
         target_o = pc_i + j_imm;
      end else if ((instr_i[6:0] == OPCODE_BRANCH) && instr_i[31]) begin
         taken_o  = 1'b1;
         target_o = pc_i + b_imm;
      end
   end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage.
// Sequences fetch addresses into a single-cycle synchronous instruction
// memory and presents the response to IF/ID with a valid/ready_go/allow_in
// handshake. One fetch may be in flight and one instruction may sit in the
// skid buffer, so a stall from decode never loses a response.
// Optional feature: define STATIC_BP_EN to predict JAL and backward
// branches taken; otherwise fetch is purely sequential between redirects.
module if_stage #(
   parameter int unsigned          BUS_WIDTH  = if_stage_pkg::BUS_WIDTH,
   parameter int unsigned          DATA_WIDTH = if_stage_pkg::DATA_WIDTH,
   parameter logic [BUS_WIDTH-1:0] RESET_PC   = if_stage_pkg::DEFAULT_RESET_PC
) (
   input logic        clk,
   input logic        rst_n,
   if_stage_if.master fetch_io
);
   import if_stage_pkg::*;

   localparam logic [BUS_WIDTH-1:0] WORD_MASK = ~BUS_WIDTH'(3);

   if_stage_pkg::if_state_e state_q, state_d;

   logic [BUS_WIDTH-1:0]  inflight_pc_q;
   logic [BUS_WIDTH-1:0]  buf_pc_q, buf_pc_d;
   logic [DATA_WIDTH-1:0] buf_instr_q, buf_instr_d;
   logic                  buf_valid_q, buf_valid_d;

   logic [BUS_WIDTH-1:0]  pres_pc;
   logic [DATA_WIDTH-1:0] pres_instr;
   logic                  pres_valid;
   logic                  pred_taken;
   logic [BUS_WIDTH-1:0]  pred_target;
   logic [BUS_WIDTH-1:0]  next_pc;
   logic                  fetch_req;
   logic [BUS_WIDTH-1:0]  fetch_addr;

   // Select what is shown to decode: the live response in RUN, the skid
   // buffer in HOLD, nothing meaningful in BOOT.
   always_comb begin
      pres_pc    = '0;
      pres_instr = '0;
      case (state_q)
         IF_RUN: begin
            pres_pc    = inflight_pc_q;
            pres_instr = fetch_io.imem_rdata;
         end
         IF_HOLD: begin
            pres_pc    = buf_pc_q;
            pres_instr = buf_instr_q;
         end
         default: begin
            pres_pc    = '0;
            pres_instr = '0;
         end
      endcase
   end

`ifdef STATIC_BP_EN
   static_bp #(
      .BUS_WIDTH  (BUS_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_static_bp (
      .pc_i     (pres_pc),
      .instr_i  (pres_instr),
      .taken_o  (pred_taken),
      .target_o (pred_target)
   );
`else
   assign pred_taken  = 1'b0;
   assign pred_target = pres_pc + BUS_WIDTH'(4);
`endif

   assign next_pc = pred_taken ? pred_target : (pres_pc + BUS_WIDTH'(4));

   // Next-state, fetch request and skid-buffer capture; redirect overrides
   // every state and discards both the in-flight response and the buffer.
   always_comb begin
      state_d     = state_q;
      fetch_req   = 1'b0;
      fetch_addr  = '0;
      pres_valid  = 1'b0;
      buf_valid_d = buf_valid_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      if (!rst_n) begin
         state_d     = IF_BOOT;
         buf_valid_d = 1'b0;
      end else if (fetch_io.redirect_valid) begin
         fetch_req   = 1'b1;
         fetch_addr  = fetch_io.redirect_pc & WORD_MASK;
         buf_valid_d = 1'b0;
         state_d     = IF_RUN;
      end else begin
         case (state_q)
            IF_BOOT: begin
               fetch_req  = 1'b1;
               fetch_addr = RESET_PC & WORD_MASK;
               state_d    = IF_RUN;
            end
            IF_RUN: begin
               pres_valid = 1'b1;
               if (fetch_io.allow_in_id) begin
                  fetch_req  = 1'b1;
                  fetch_addr = next_pc & WORD_MASK;
               end else begin
                  buf_valid_d = 1'b1;
                  buf_pc_d    = pres_pc;
                  buf_instr_d = pres_instr;
                  state_d     = IF_HOLD;
               end
            end
            IF_HOLD: begin
               pres_valid = buf_valid_q;
               if (fetch_io.allow_in_id) begin
                  fetch_req   = 1'b1;
                  fetch_addr  = next_pc & WORD_MASK;
                  buf_valid_d = 1'b0;
                  state_d     = IF_RUN;
               end
            end
            default: begin
               state_d = IF_BOOT;
            end
         endcase
      end
   end

   // State, in-flight PC and skid-buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IF_BOOT;
         inflight_pc_q <= '0;
         buf_valid_q   <= 1'b0;
         buf_pc_q      <= '0;
         buf_instr_q   <= '0;
      end else begin
         state_q     <= state_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         if (fetch_req) begin
            inflight_pc_q <= fetch_addr;
         end
      end
   end

   assign fetch_io.imem_req            = fetch_req;
   assign fetch_io.imem_addr           = fetch_addr;
   assign fetch_io.valid_if            = pres_valid;
   assign fetch_io.ready_go_if         = 1'b1;
   assign fetch_io.pc_if               = rst_n ? pres_pc : '0;
   assign fetch_io.instruction_if      = rst_n ? pres_instr : '0;
   assign fetch_io.bp_taken_if         = rst_n ? pred_taken : 1'b0;
   assign fetch_io.pre_taken_target_if = rst_n ? pred_target : '0;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage.
// A behavioural model tracks only "which PC is decode looking at" and checks
// every cycle; directed literal checks pin the model at key points.
module tb_if_stage;

   logic clk;
   logic rst_n;

   int compareCount = 0;
   int failCount    = 0;

   if_stage_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) busIf ();

   if_stage #(
      .BUS_WIDTH  (32),
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .fetch_io (busIf)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Program image: a few control-flow instructions at fixed spots, and
   // elsewhere an addi whose upper bits encode its own address.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      case (addr)
         32'h0000_0020: memWord = 32'hFE00_0EE3;
         32'h0000_0040: memWord = 32'h0100_006F;
         32'h0000_0060: memWord = 32'h0000_0463;
         default:       memWord = {addr[26:2], 7'h13};
      endcase
   endfunction

   // Synchronous instruction memory; returns garbage when not requested so
   // any reliance on a stale response shows up.
   always @(posedge clk) begin
      busIf.imem_rdata <= busIf.imem_req ? memWord(busIf.imem_addr) : 32'hDEAD_BEEF;
   end

   // Static prediction rule computed from instruction fields arithmetically.
   function automatic void predict(input logic [31:0] pc, input logic [31:0] ins,
                                   output logic taken, output logic [31:0] tgt);
      int imm;
      taken = 1'b0;
      tgt   = pc + 32'd4;
      imm   = 0;
`ifdef STATIC_BP_EN
      if (ins[6:0] == 7'b1101111) begin
         imm   = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                 - (ins[31] ? 1048576 : 0);
         taken = 1'b1;
         tgt   = pc + 32'(imm);
      end else if (ins[6:0] == 7'b1100011 && ins[31]) begin
         imm   = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048 - 4096;
         taken = 1'b1;
         tgt   = pc + 32'(imm);
      end
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rstN, input logic allow, input logic redir,
                                input logic [31:0] rpc);
      @(posedge clk);
      #1;
      rst_n                = rstN;
      busIf.allow_in_id    = allow;
      busIf.redirect_valid = redir;
      busIf.redirect_pc    = rpc;
      #2;
   endtask

   logic        showing = 1'b0;
   logic [31:0] livePc  = 32'h0;

   // Model: decode sees one instruction at livePc once something was fetched;
   // it advances on allow, restarts at a redirect target after a bubble.
   always @(negedge clk) begin
      logic        expTaken;
      logic [31:0] expTgt;
      checkOutput("ready_go", 32'(busIf.ready_go_if), 32'd1);
      if (!rst_n) begin
         checkOutput("rst_req",    32'(busIf.imem_req), 32'd0);
         checkOutput("rst_valid",  32'(busIf.valid_if), 32'd0);
         checkOutput("rst_pc",     busIf.pc_if, 32'd0);
         checkOutput("rst_instr",  busIf.instruction_if, 32'd0);
         checkOutput("rst_bp",     32'(busIf.bp_taken_if), 32'd0);
         checkOutput("rst_target", busIf.pre_taken_target_if, 32'd0);
         showing = 1'b0;
      end else if (busIf.redirect_valid) begin
         checkOutput("m_redir_valid", 32'(busIf.valid_if), 32'd0);
         checkOutput("m_redir_req",   32'(busIf.imem_req), 32'd1);
         checkOutput("m_redir_addr",  busIf.imem_addr, busIf.redirect_pc & ~32'd3);
         showing = 1'b1;
         livePc  = busIf.redirect_pc & ~32'd3;
      end else if (!showing) begin
         checkOutput("m_boot_valid", 32'(busIf.valid_if), 32'd0);
         checkOutput("m_boot_req",   32'(busIf.imem_req), 32'd1);
         checkOutput("m_boot_addr",  busIf.imem_addr, 32'd0);
         showing = 1'b1;
         livePc  = 32'd0;
      end else begin
         predict(livePc, memWord(livePc), expTaken, expTgt);
         checkOutput("m_valid",  32'(busIf.valid_if), 32'd1);
         checkOutput("m_pc",     busIf.pc_if, livePc);
         checkOutput("m_instr",  busIf.instruction_if, memWord(livePc));
         checkOutput("m_bp",     32'(busIf.bp_taken_if), 32'(expTaken));
         checkOutput("m_target", busIf.pre_taken_target_if, expTgt);
         if (busIf.allow_in_id) begin
            checkOutput("m_req",  32'(busIf.imem_req), 32'd1);
            checkOutput("m_addr", busIf.imem_addr, (expTaken ? expTgt : livePc + 32'd4) & ~32'd3);
            livePc = (expTaken ? expTgt : livePc + 32'd4) & ~32'd3;
         end else begin
            checkOutput("m_stall_req", 32'(busIf.imem_req), 32'd0);
         end
      end
   end

   // Directed sequence with hand-computed literal expectations.
   initial begin
      logic [15:0] allowPattern;
      allowPattern         = 16'b1011_0011_1000_1101;
      rst_n                = 1'b0;
      busIf.allow_in_id    = 1'b1;
      busIf.redirect_valid = 1'b0;
      busIf.redirect_pc    = 32'h0;

      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("reset_req", 32'(busIf.imem_req), 32'd0);
      checkOutput("reset_valid", 32'(busIf.valid_if), 32'd0);

      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("boot_addr", busIf.imem_addr, 32'h0);
      checkOutput("boot_valid", 32'(busIf.valid_if), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("seq_pc0", busIf.pc_if, 32'h0);
      checkOutput("seq_addr4", busIf.imem_addr, 32'h4);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("seq_pc4", busIf.pc_if, 32'h4);
      checkOutput("seq_addr8", busIf.imem_addr, 32'h8);

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
         checkOutput("stall_req", 32'(busIf.imem_req), 32'd0);
         checkOutput("stall_pc", busIf.pc_if, 32'h8);
         checkOutput("stall_instr", busIf.instruction_if, 32'h0000_0113);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("release_addr", busIf.imem_addr, 32'hC);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("release_pc", busIf.pc_if, 32'hC);

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("hold_pc", busIf.pc_if, 32'h10);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h103);
      checkOutput("hold_redir_valid", 32'(busIf.valid_if), 32'd0);
      checkOutput("hold_redir_addr", busIf.imem_addr, 32'h100);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("hold_redir_pc", busIf.pc_if, 32'h100);
      checkOutput("hold_redir_instr", busIf.instruction_if, 32'h0000_2013);

      applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
      checkOutput("run_redir_addr", busIf.imem_addr, 32'h200);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("run_redir_pc", busIf.pc_if, 32'h200);
      checkOutput("run_redir_instr", busIf.instruction_if, 32'h0000_4013);

      applyStimulus(1'b1, 1'b1, 1'b1, 32'h20);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("beq_instr", busIf.instruction_if, 32'hFE00_0EE3);
`ifdef STATIC_BP_EN
      checkOutput("beq_taken", 32'(busIf.bp_taken_if), 32'd1);
      checkOutput("beq_target", busIf.pre_taken_target_if, 32'h1C);
      checkOutput("beq_addr", busIf.imem_addr, 32'h1C);
`else
      checkOutput("beq_taken", 32'(busIf.bp_taken_if), 32'd0);
      checkOutput("beq_target", busIf.pre_taken_target_if, 32'h24);
      checkOutput("beq_addr", busIf.imem_addr, 32'h24);
`endif
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef STATIC_BP_EN
      checkOutput("jal_addr", busIf.imem_addr, 32'h50);
`else
      checkOutput("jal_addr", busIf.imem_addr, 32'h44);
`endif
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h60);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("fwd_br_taken", 32'(busIf.bp_taken_if), 32'd0);
      checkOutput("fwd_br_addr", busIf.imem_addr, 32'h64);

      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("wrap_pc", busIf.pc_if, 32'hFFFF_FFFC);
      checkOutput("wrap_addr", busIf.imem_addr, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("wrap_next_pc", busIf.pc_if, 32'h0);

      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("midrst_req", 32'(busIf.imem_req), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("midrst_boot_addr", busIf.imem_addr, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("midrst_pc", busIf.pc_if, 32'h0);

      for (int i = 0; i < 48; i++) begin
         applyStimulus(1'b1, allowPattern[i % 16], (i % 13) == 12, 32'h0000_0038);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
